sd_spi_seq: RTL and testbench
=============================

# sd_spi_seq

Bus-master sequencer that drives the simulated SD/SPI byte-exchange peripheral to execute one SD command per request. It issues a leading 0xFF pad and a 6-byte command frame with a generated CRC7, then polls for the R1 response. It optionally collects 4 extra response bytes, and optionally reads a data token, a block of data bytes and 2 CRC bytes. It sits between the firmware-visible control registers (or a boot loader) and the peripheral's bus slave port, and owns that port exclusively.

## Interface
- BASE_ADDR, 32'h0000_0008: address of the peripheral's SPI data register.
- BLOCK_LEN, 512: data bytes per block read.
- RESP_TIMEOUT, 16: maximum 0xFF bytes polled before R1.
- TOKEN_TIMEOUT, 4096: maximum 0xFF bytes polled before the data token.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  command request, sampled in IDLE only.
- cmd_idx  in  6  SD command index.
- cmd_arg  in  32  command argument.
- resp_ext  in  1  collect 4 extra response bytes (R3/R7).
- rd_blk  in  1  command returns a data block.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  2  0 ok, 1 R1 timeout, 2 R1 error, 3 token timeout/error token; valid with done, held until next start.
- r1  out  8  captured R1 byte.
- r_ext  out  32  extra response bytes, big-endian (first byte in [31:24]).
- out_valid / out_ready  out / in  1  data byte stream handshake.
- out_byte  out  8  data byte.
- spi_cs  out  1  peripheral select strobe.
- spi_addr  out  32  peripheral address.
- spi_wr_val  out  32  write data; byte in [7:0], upper bits 0.
- spi_bytesel  out  4  4'b0001 = write/exchange, 4'b1111 = read.
- spi_ack  in  1  peripheral acknowledge (one cycle after cs).
- spi_data  in  32  peripheral read data, valid with ack; received byte in [7:0].

## Operation
- Byte exchange (XCHG), fixed 4 phases:
  - WR: spi_cs=1 for exactly one cycle, bytesel 4'b0001, addr BASE_ADDR, wr_val={24'b0,tx}.
  - WA: wait for spi_ack.
  - RD: spi_cs=1 for one cycle, bytesel 4'b1111.
  - RA: wait for spi_ack, then capture spi_data[7:0] as rx.
  - spi_cs must never be high on two consecutive cycles, because the peripheral performs one exchange per cs cycle.
- Top FSM:
  - IDLE: on start, latch inputs, clear err/r1/r_ext, busy=1.
  - CMD: 7 exchanges of tx = FF, {2'b01,cmd_idx}, arg[31:24..7:0], {crc7,1'b1}.
  - RESP: send FF until rx[7]==0, then r1=rx. After RESP_TIMEOUT polls without it → err=1, go to FIN.
  - If r1[6:1]!=0 → err=2, go to FIN; the idle bit r1[0] is not an error.
  - EXT (resp_ext only): 4 exchanges, shifted into r_ext.
  - TOKEN (rd_blk only): send FF. rx==FE → DATA. rx==FF counts toward timeout. Any other rx → err=3, FIN. Timeout → err=3.
  - DATA: BLOCK_LEN exchanges. Each rx is presented on out_byte with out_valid=1. The next exchange does not start until out_valid&&out_ready.
  - CRC: 2 exchanges, bytes discarded.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- CRC7: polynomial x^7+x^3+1, init 0, over the 5 bytes after the pad, MSB first.
- start while busy is ignored. out_valid is never asserted outside DATA.

## Timing
- Reset values: spi_cs=0, spi_addr=0, spi_wr_val=0, spi_bytesel=0, busy=0, done=0, err=0, r1=8'hFF, r_ext=0, out_valid=0, out_byte=0; FSM in IDLE.
- All outputs are registered. start is sampled at cycle N; the first WR strobe occurs at N+1.
- Exchange latency is 4 cycles with the peripheral's 1-cycle ack. Back-to-back exchanges add no idle cycles.
- CMD0 with no response delay: 7 exchanges plus 1 R1 exchange → done asserted 33 cycles after the start sample.
- out_valid rises the cycle after RA capture and holds with stable out_byte until out_ready is high.
- rst mid-operation: at the next edge return to IDLE with reset values, regardless of phase. Any spi_ack arriving after reset is ignored.

## Structure
- Shared package `sd_spi_pkg`:
  - FSM state enum and exchange-phase enum.
  - Error code constants ERR_OK/ERR_R1_TO/ERR_R1/ERR_TOKEN.
  - Constants START_TOKEN=8'hFE and bytesel codes.
- Sub-module `sd_crc7`: byte-serial CRC7 with clear, enable and data_in, producing a 7-bit crc.

## Test plan
- CMD0, arg 0, peripheral model returns FF,FF,01 → bus write bytes FF,40,00,00,00,00,95. r1=01, err=0, done once, no out_valid.
- CMD8, arg 32'h1AA, resp_ext=1, model returns 01 then 00,00,01,AA → frame 48,00,00,01,AA,87. r_ext=32'h000001AA.
- CMD17 with rd_blk=1, token FE after 3 FFs, 512-byte ramp 00..FF,00..FF → 512 stream bytes in order. out_ready toggled randomly with no loss. 2 CRC exchanges, err=0.
- Model returns only FF → err=1 after exactly 16 R1 polls. TOKEN_TIMEOUT case → err=3. Token 8'h05 → err=3 immediately.
- Protocol checker throughout: spi_cs never high for 2 consecutive cycles, and every write is followed by exactly one read before the next write.
- rst asserted during DATA byte 100 → all outputs at reset values the next cycle. A new start completes CMD0 normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD/SPI command sequencer: FSM and
// exchange-phase encodings, error codes and peripheral byte-select codes.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP,
    ST_EXT,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_FIN
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_WR,
    PH_WA,
    PH_RD,
    PH_RA
  } xchg_phase_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_R1_TO = 2'd1;
  localparam logic [1:0] ERR_R1    = 2'd2;
  localparam logic [1:0] ERR_TOKEN = 2'd3;

  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

  localparam logic [3:0] BSEL_XCHG = 4'b0001;
  localparam logic [3:0] BSEL_READ = 4'b1111;

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 (x^7 + x^3 + 1, MSB first); one whole byte folded in per
// enabled cycle, clear takes priority over enable.
module sd_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 7'd0;
    else if (en) crc_d = crc7_byte(crc_q, data_in);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 7'd0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_spi_seq.sv
// SD command sequencer: drives the SPI byte-exchange peripheral through pad,
// command frame, R1 poll, optional extended response and optional data block.
module sd_spi_seq
  import sd_spi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0008,
  parameter int          BLOCK_LEN     = 512,
  parameter int          RESP_TIMEOUT  = 16,
  parameter int          TOKEN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        resp_ext,
  input  logic        rd_blk,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [7:0]  r1,
  output logic [31:0] r_ext,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        spi_cs,
  output logic [31:0] spi_addr,
  output logic [31:0] spi_wr_val,
  output logic [3:0]  spi_bytesel,
  input  logic        spi_ack,
  input  logic [31:0] spi_data
);

  localparam logic [15:0] RESP_LAST = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] TOK_LAST  = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [15:0] BLK_LAST  = 16'(BLOCK_LEN - 1);

  seq_state_e  state_q, state_d;
  xchg_phase_e ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d;
  logic        cs_q, cs_d, busy_q, busy_d, done_q, done_d, ov_q, ov_d;
  logic [31:0] addr_q, addr_d, wr_q, wr_d, rext_q, rext_d;
  logic [3:0]  bsel_q, bsel_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  r1_q, r1_d, ob_q, ob_d;

  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic        ext_q, blk_q;

  logic        launch, cmd_launch, xdone, crc_clr, crc_en;
  logic [2:0]  cmd_k;
  logic [7:0]  tx, rx;
  logic [6:0]  crc_val;
  logic        unused_hi;

  assign unused_hi = ^spi_data[31:8];

  function automatic logic [7:0] cmd_byte(input logic [2:0] k, input logic [5:0] idx,
                                          input logic [31:0] arg, input logic [6:0] c);
    case (k)
      3'd1:    return {2'b01, idx};
      3'd2:    return arg[31:24];
      3'd3:    return arg[23:16];
      3'd4:    return arg[15:8];
      3'd5:    return arg[7:0];
      3'd6:    return {c, 1'b1};
      default: return IDLE_BYTE;
    endcase
  endfunction

  sd_crc7 u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .data_in (tx),
    .crc     (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    cs_d       = 1'b0;
    addr_d     = addr_q;
    wr_d       = wr_q;
    bsel_d     = bsel_q;
    err_d      = err_q;
    r1_d       = r1_q;
    rext_d     = rext_q;
    ov_d       = ov_q;
    ob_d       = ob_q;
    launch     = 1'b0;
    cmd_launch = 1'b0;
    cmd_k      = 3'd0;
    crc_clr    = 1'b0;
    rx         = spi_data[7:0];
    xdone      = (ph_q == PH_RA) && spi_ack;

    // Exchange engine: WR strobe, wait ack, RD strobe, wait ack.
    case (ph_q)
      PH_WR: ph_d = PH_WA;
      PH_WA: if (spi_ack) begin
        ph_d   = PH_RD;
        cs_d   = 1'b1;
        bsel_d = BSEL_READ;
      end
      PH_RD: ph_d = PH_RA;
      PH_RA: if (spi_ack) ph_d = PH_IDLE;
      default: ;
    endcase

    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CMD;
        cnt_d   = 16'd0;
        err_d   = ERR_OK;
        r1_d    = 8'hFF;
        rext_d  = 32'd0;
        crc_clr = 1'b1;
      end
      ST_CMD: begin
        if (ph_q == PH_IDLE) begin
          launch = 1'b1;
        end else if (xdone) begin
          launch = 1'b1;
          if (cnt_q == 16'd6) begin
            state_d = ST_RESP;
            cnt_d   = 16'd0;
          end else begin
            cnt_d      = cnt_q + 16'd1;
            cmd_launch = 1'b1;
            cmd_k      = cnt_q[2:0] + 3'd1;
          end
        end
      end
      ST_RESP: if (xdone) begin
        if (!rx[7]) begin
          r1_d  = rx;
          cnt_d = 16'd0;
          if (rx[6:1] != 6'd0) begin
            err_d   = ERR_R1;
            state_d = ST_FIN;
          end else if (ext_q) begin
            state_d = ST_EXT;
            launch  = 1'b1;
          end else if (blk_q) begin
            state_d = ST_TOKEN;
            launch  = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else if (cnt_q == RESP_LAST) begin
          err_d   = ERR_R1_TO;
          state_d = ST_FIN;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          launch = 1'b1;
        end
      end
      ST_EXT: if (xdone) begin
        rext_d = {rext_q[23:0], rx};
        if (cnt_q == 16'd3) begin
          cnt_d = 16'd0;
          if (blk_q) begin
            state_d = ST_TOKEN;
            launch  = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          cnt_d  = cnt_q + 16'd1;
          launch = 1'b1;
        end
      end
      ST_TOKEN: if (xdone) begin
        if (rx == START_TOKEN) begin
          state_d = ST_DATA;
          cnt_d   = 16'd0;
          launch  = 1'b1;
        end else if (rx != IDLE_BYTE || cnt_q == TOK_LAST) begin
          err_d   = ERR_TOKEN;
          state_d = ST_FIN;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          launch = 1'b1;
        end
      end
      ST_DATA: begin
        // The next exchange is held off until the sink has taken this byte.
        if (xdone) begin
          ov_d = 1'b1;
          ob_d = rx;
        end else if (ov_q && out_ready) begin
          ov_d   = 1'b0;
          launch = 1'b1;
          if (cnt_q == BLK_LAST) begin
            state_d = ST_CRC;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_CRC: if (xdone) begin
        if (cnt_q == 16'd1) begin
          state_d = ST_FIN;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          launch = 1'b1;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    tx     = cmd_byte(cmd_k, idx_q, arg_q, crc_val);
    crc_en = cmd_launch && (cmd_k != 3'd6);

    if (launch) begin
      ph_d   = PH_WR;
      cs_d   = 1'b1;
      bsel_d = BSEL_XCHG;
      addr_d = BASE_ADDR;
      wr_d   = {24'd0, tx};
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= PH_IDLE;
      cnt_q   <= 16'd0;
      cs_q    <= 1'b0;
      addr_q  <= 32'd0;
      wr_q    <= 32'd0;
      bsel_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= ERR_OK;
      r1_q    <= 8'hFF;
      rext_q  <= 32'd0;
      ov_q    <= 1'b0;
      ob_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      bsel_q  <= bsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      r1_q    <= r1_d;
      rext_q  <= rext_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      idx_q <= cmd_idx;
      arg_q <= cmd_arg;
      ext_q <= resp_ext;
      blk_q <= rd_blk;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign r1          = r1_q;
  assign r_ext       = rext_q;
  assign out_valid   = ov_q;
  assign out_byte    = ob_q;
  assign spi_cs      = cs_q;
  assign spi_addr    = addr_q;
  assign spi_wr_val  = wr_q;
  assign spi_bytesel = bsel_q;

endmodule

// File: tb/tb_sd_spi_seq.sv
// Bench for sd_spi_seq: scripted/randomised SD peripheral model, protocol
// monitor and a byte-level reference of the command/response sequence.
`timescale 1ns/1ps
module tb_sd_spi_seq;

  localparam logic [31:0] BASE = 32'h0000_0008;
  localparam int BLK = 512;
  localparam int RTO = 16;
  localparam int TTO = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        resp_ext = 1'b0;
  logic        rd_blk = 1'b0;
  logic        busy, done, out_valid, spi_cs;
  logic [1:0]  err;
  logic [7:0]  r1, out_byte;
  logic [31:0] r_ext, spi_addr, spi_wr_val;
  logic [3:0]  spi_bytesel;
  logic        out_ready = 1'b1;
  logic        spi_ack = 1'b0;
  logic [31:0] spi_data = '0;

  always #5 clk = ~clk;

  sd_spi_seq #(.BASE_ADDR(BASE), .BLOCK_LEN(BLK), .RESP_TIMEOUT(RTO), .TOKEN_TIMEOUT(TTO)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .resp_ext(resp_ext), .rd_blk(rd_blk), .busy(busy), .done(done), .err(err),
    .r1(r1), .r_ext(r_ext), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .spi_cs(spi_cs), .spi_addr(spi_addr), .spi_wr_val(spi_wr_val),
    .spi_bytesel(spi_bytesel), .spi_ack(spi_ack), .spi_data(spi_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Peripheral model: rx is FF during the 7-byte frame, then the script.
  logic [7:0] scr[$];
  logic [7:0] tx_log[$];
  int         scr_i = 0;
  int         wr_n = 0;
  logic [7:0] rx_hold = 8'hFF;

  always @(posedge clk) begin
    spi_ack <= 1'b0;
    if (start) begin
      wr_n  <= 0;
      scr_i <= 0;
      tx_log.delete();
    end else if (spi_cs) begin
      spi_ack <= 1'b1;
      if (spi_bytesel == 4'b0001) begin
        tx_log.push_back(spi_wr_val[7:0]);
        if (wr_n < 7) rx_hold <= 8'hFF;
        else begin
          rx_hold <= (scr_i < scr.size()) ? scr[scr_i] : 8'hFF;
          scr_i   <= scr_i + 1;
        end
        wr_n <= wr_n + 1;
      end else begin
        spi_data <= {24'hA5C3E1, rx_hold};
      end
    end
  end

  // Monitors: bus protocol, stream capture, out_valid hold, done count.
  int         done_n = 0;
  int         ov_n = 0;
  logic [7:0] got_q[$];
  logic       prev_cs = 1'b0;
  logic       rd_due = 1'b0;
  logic       ov_pend = 1'b0;
  logic [7:0] pend_b = 8'h00;

  always @(posedge clk) begin
    if (start) begin
      done_n <= 0;
      ov_n   <= 0;
      got_q.delete();
    end else if (!rst) begin
      if (done) done_n <= done_n + 1;
      if (out_valid) ov_n <= ov_n + 1;
      if (out_valid && out_ready) got_q.push_back(out_byte);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      prev_cs <= 1'b0;
      rd_due  <= 1'b0;
      ov_pend <= 1'b0;
    end else begin
      prev_cs <= spi_cs;
      if (spi_cs) begin
        chk("cs_b2b", 32'(prev_cs), 0);
        chk("cs_addr", spi_addr, BASE);
        if (spi_bytesel == 4'b0001) begin
          chk("wr_order", 32'(rd_due), 0);
          chk("wr_upper", 32'(spi_wr_val[31:8]), 0);
          rd_due <= 1'b1;
        end else begin
          chk("rd_sel", 32'(spi_bytesel), 32'hF);
          chk("rd_order", 32'(rd_due), 1);
          rd_due <= 1'b0;
        end
      end
      if (ov_pend) chk("ov_hold", 32'({out_valid, out_byte}), 32'({1'b1, pend_b}));
      ov_pend <= out_valid && !out_ready;
      pend_b  <= out_byte;
    end
  end

  int rdy_mode = 0;
  initial begin
    forever begin
      @(negedge clk);
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model
  logic [7:0]  e_r1;
  logic [1:0]  e_err;
  logic [31:0] e_rext;
  int          e_nx;
  logic [7:0]  e_data[$];

  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int k = 46; k >= 7; k--)
      if (r[k]) r[k -: 8] = r[k -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [7:0] sb(input int i);
    if (i < scr.size()) return scr[i];
    return 8'hFF;
  endfunction

  task automatic predict(input bit ext, input bit blk);
    int i;
    bit found, stop;
    logic [7:0] b;
    i = 0; found = 0; stop = 0;
    e_err = 0; e_r1 = 8'hFF; e_rext = 0; e_data.delete();
    for (int p = 0; p < RTO && !found; p++) begin
      b = sb(i); i++;
      if (!b[7]) begin found = 1; e_r1 = b; end
    end
    if (!found) begin e_err = 1; stop = 1; end
    else if (e_r1[6:1] != 6'd0) begin e_err = 2; stop = 1; end
    if (!stop && ext)
      for (int k = 0; k < 4; k++) begin e_rext = {e_rext[23:0], sb(i)}; i++; end
    if (!stop && blk) begin
      found = 0;
      for (int t = 0; t < TTO && !found && !stop; t++) begin
        b = sb(i); i++;
        if (b == 8'hFE) found = 1;
        else if (b != 8'hFF) stop = 1;
      end
      if (!found) begin e_err = 3; stop = 1; end
      if (!stop) begin
        for (int k = 0; k < BLK; k++) begin e_data.push_back(sb(i)); i++; end
        i += 2;
      end
    end
    e_nx = 7 + i;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input bit ext, input bit blk);
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; resp_ext = ext; rd_blk = blk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [5:0] idx, input logic [31:0] arg,
                         input bit ext, input bit blk, output int lat);
    logic [7:0] fr[7];
    int n, bad;
    predict(ext, blk);
    issue(idx, arg, ext, blk);
    chk({nm, ":busy"}, 32'(busy), 1);
    n = 0;
    while (!done && n < 30000) begin @(posedge clk); #1; n++; end
    lat = n;
    chk({nm, ":done_seen"}, 32'(done), 1);
    chk({nm, ":busy_fin"}, 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, ":done_once"}, 32'(done_n), 1);
    chk({nm, ":err"}, 32'(err), 32'(e_err));
    if (e_err != 2'd1) chk({nm, ":r1"}, 32'(r1), 32'(e_r1));
    if (ext && e_err == 2'd0) chk({nm, ":r_ext"}, r_ext, e_rext);
    fr[0] = 8'hFF;
    fr[1] = {2'b01, idx};
    fr[2] = arg[31:24]; fr[3] = arg[23:16]; fr[4] = arg[15:8]; fr[5] = arg[7:0];
    fr[6] = {ref_crc7({2'b01, idx, arg}), 1'b1};
    chk({nm, ":n_xchg"}, 32'(tx_log.size()), 32'(e_nx));
    bad = 0;
    for (int k = 0; k < tx_log.size(); k++)
      if (tx_log[k] !== ((k < 7) ? fr[k] : 8'hFF)) bad++;
    chk({nm, ":tx_bytes_bad"}, 32'(bad), 0);
    if (e_data.size() != 0) begin
      chk({nm, ":stream_len"}, 32'(got_q.size()), 32'(BLK));
      bad = 0;
      for (int k = 0; k < BLK; k++)
        if (k >= got_q.size() || got_q[k] !== e_data[k]) bad++;
      chk({nm, ":stream_bad"}, 32'(bad), 0);
    end else begin
      chk({nm, ":no_ov"}, 32'(ov_n), 0);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, ":cs"}, 32'(spi_cs), 0);
    chk({nm, ":addr"}, spi_addr, 0);
    chk({nm, ":wr_val"}, spi_wr_val, 0);
    chk({nm, ":bsel"}, 32'(spi_bytesel), 0);
    chk({nm, ":busy"}, 32'(busy), 0);
    chk({nm, ":done"}, 32'(done), 0);
    chk({nm, ":err"}, 32'(err), 0);
    chk({nm, ":r1"}, 32'(r1), 32'hFF);
    chk({nm, ":r_ext"}, r_ext, 0);
    chk({nm, ":ov"}, 32'(out_valid), 0);
    chk({nm, ":ob"}, 32'(out_byte), 0);
  endtask

  initial begin
    int lat, n, d;
    bit ext, blk;
    logic [7:0] r1b;

    repeat (3) @(posedge clk);
    #1;
    chk_rst("reset");
    @(negedge clk);
    rst = 1'b0;

    // CMD0 with two idle polls before R1
    scr.delete(); scr.push_back(8'hFF); scr.push_back(8'hFF); scr.push_back(8'h01);
    run_cmd("cmd0", 6'd0, 32'd0, 0, 0, lat);
    chk("cmd0:crc_byte", 32'(tx_log.size() > 6 ? tx_log[6] : 8'h00), 32'h95);
    chk("cmd0:r1_const", 32'(r1), 32'h01);

    // CMD0 with R1 on the first poll: fixed latency
    scr.delete(); scr.push_back(8'h01);
    run_cmd("cmd0_lat", 6'd0, 32'd0, 0, 0, lat);
    chk("cmd0_lat:cycles", 32'(lat), 33);

    // CMD8 with R7 extension
    scr.delete();
    scr.push_back(8'h01); scr.push_back(8'h00); scr.push_back(8'h00);
    scr.push_back(8'h01); scr.push_back(8'hAA);
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1, 0, lat);
    chk("cmd8:crc_byte", 32'(tx_log.size() > 6 ? tx_log[6] : 8'h00), 32'h87);
    chk("cmd8:r_ext_const", r_ext, 32'h0000_01AA);

    // CMD17 block read, ramp data, random out_ready
    scr.delete();
    scr.push_back(8'h00);
    repeat (3) scr.push_back(8'hFF);
    scr.push_back(8'hFE);
    for (int k = 0; k < BLK; k++) scr.push_back(8'(k));
    scr.push_back(8'h12); scr.push_back(8'h34);
    rdy_mode = 1;
    run_cmd("cmd17", 6'd17, $urandom, 0, 1, lat);
    chk("cmd17:err_const", 32'(err), 0);
    rdy_mode = 0;

    // R1 timeout, R1 error, token timeout, bad token
    scr.delete();
    run_cmd("r1_to", 6'd1, 32'd0, 0, 0, lat);
    chk("r1_to:n_const", 32'(tx_log.size()), 7 + RTO);
    scr.delete(); scr.push_back(8'hFF); scr.push_back(8'h04);
    run_cmd("r1_err", 6'd2, 32'h1234_5678, 1, 1, lat);
    scr.delete(); scr.push_back(8'h00);
    run_cmd("tok_to", 6'd17, 32'h0000_0200, 0, 1, lat);
    chk("tok_to:err_const", 32'(err), 3);
    scr.delete(); scr.push_back(8'h00); scr.push_back(8'h05);
    run_cmd("tok_bad", 6'd17, 32'h0000_0400, 0, 1, lat);
    chk("tok_bad:n_const", 32'(tx_log.size()), 9);

    // Randomised commands and responses
    for (int r = 0; r < 6; r++) begin
      scr.delete();
      ext = 1'($urandom_range(0, 1));
      blk = ($urandom_range(0, 2) == 0);
      d = $urandom_range(0, 17);
      repeat (d) scr.push_back(8'hFF);
      case ($urandom_range(0, 3))
        0:       r1b = 8'h00;
        1:       r1b = 8'h01;
        2:       r1b = 8'($urandom_range(0, 127));
        default: r1b = 8'h01;
      endcase
      scr.push_back(r1b);
      if (ext) repeat (4) scr.push_back(8'($urandom));
      if (blk) begin
        d = $urandom_range(0, 5);
        repeat (d) scr.push_back(8'hFF);
        scr.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE);
        repeat (BLK + 2) scr.push_back(8'($urandom));
      end
      rdy_mode = $urandom_range(0, 1);
      run_cmd($sformatf("rnd%0d", r), 6'($urandom), $urandom, ext, blk, lat);
    end
    rdy_mode = 0;

    // Reset in the middle of the data block
    scr.delete();
    scr.push_back(8'h00); scr.push_back(8'hFE);
    repeat (BLK + 2) scr.push_back(8'($urandom));
    issue(6'd17, 32'd0, 0, 1);
    n = 0;
    while (got_q.size() < 100 && n < 20000) begin @(posedge clk); #1; n++; end
    chk("mid_rst:reach100", 32'(got_q.size() >= 100), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_rst("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst:quiet_busy", 32'(busy), 0);
    chk("mid_rst:quiet_cs", 32'(spi_cs), 0);

    scr.delete(); scr.push_back(8'h01);
    run_cmd("post_rst", 6'd0, 32'd0, 0, 0, lat);
    chk("post_rst:cycles", 32'(lat), 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
